// File: rtl/single_exp_table_arbiter.sv
// Round-robin arbiter sharing one exponent lookup table among REQUESTERS clients.
// Optional statistics outputs (grant_count, max_wait) enabled by SINGLE_EXP_ARB_STATS_EN.

module single_exponent_table #(
   parameter int  STEPS = 64,
   parameter real LIMIT = 8.0
) (
   input  logic        clk,
   input  logic        in_valid,
   input  logic [31:0] a,
   output logic        out_valid,
   output logic [31:0] c
);
   localparam int  IW   = $clog2(STEPS);
   localparam real STEP = 2.0 * LIMIT / real'(STEPS - 1);

   // Round-to-nearest-even conversion of a double to single-precision bits.
   function automatic logic [31:0] to_single(input real r);
      logic [63:0] d;
      logic [7:0]  e8;
      logic [30:0] mag;
      logic        rnd;
      if (r == 0.0) return 32'h0;
      d   = $realtobits(r);
      e8  = 8'(d[62:52] - 11'd896);
      mag = {e8, d[51:29]};
      rnd = d[28] & ((|d[27:0]) | d[29]);
      return {d[63], mag + 31'(rnd)};
   endfunction

   // Maps IEEE bits onto an unsigned key whose ordering matches numeric ordering.
   function automatic logic [31:0] order_key(input logic [31:0] f);
      if (f[30:0] == 31'd0) return 32'h8000_0000;
      return f[31] ? ~f : {1'b1, f[30:0]};
   endfunction

   logic [31:0] entry [STEPS];
   logic [31:0] bound [STEPS-1];
   logic [31:0] a_key;
   logic [IW-1:0] idx;

   for (genvar k = 0; k < STEPS; k++) begin : g_entry
      localparam logic [31:0] EV = to_single($exp(-LIMIT + real'(k) * STEP));
      assign entry[k] = EV;
   end

   // Midpoints between neighbouring entries; the input clamps naturally at both ends.
   for (genvar k = 0; k < STEPS - 1; k++) begin : g_bound
      localparam logic [31:0] BK = order_key(to_single(-LIMIT + (real'(k) + 0.5) * STEP));
      assign bound[k] = BK;
   end

   always_comb begin
      a_key = order_key(a);
      idx   = '0;
      for (int k = 0; k < STEPS - 1; k++) begin
         if (a_key >= bound[k]) idx = idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      out_valid <= in_valid;
      if (in_valid) c <= entry[idx];
   end
endmodule

module single_exp_table_arbiter #(
   parameter int  REQUESTERS = 4,
   parameter int  STEPS      = 64,
   parameter real LIMIT      = 8.0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [REQUESTERS-1:0]      req_valid,
   input  logic [32*REQUESTERS-1:0]   req_a,
   output logic [REQUESTERS-1:0]      req_ready,
   output logic [REQUESTERS-1:0]      resp_valid,
   output logic [31:0]                resp_c,
   output logic                       busy
`ifdef SINGLE_EXP_ARB_STATS_EN
   ,
   output logic [16*REQUESTERS-1:0]   grant_count,
   output logic [15:0]                max_wait
`endif
);
   localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   logic [PW-1:0]         prio_q, prio_d;
   logic                  s1_valid_q, s1_valid_d;
   logic [31:0]           s1_a_q, s1_a_d;
   logic [PW-1:0]         s1_tag_q, s1_tag_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [PW-1:0]         s2_tag_q, s2_tag_d;

   logic [REQUESTERS-1:0] grant;
   logic [PW-1:0]         win;
   logic [31:0]           win_a;
   logic                  found;
   logic                  xfer;
   logic [31:0]           tbl_c;
   logic                  tbl_valid_unused;

   always_comb begin
      int idx;
      idx   = 0;
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < REQUESTERS; k++) begin
         idx = int'(prio_q) + k;
         if (idx >= REQUESTERS) idx = idx - REQUESTERS;
         if (!found && req_valid[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      xfer = found & ~reset;
      if (xfer) grant[win] = 1'b1;
   end

   assign req_ready = grant;

   always_comb begin
      win_a = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (grant[k]) win_a = req_a[32*k +: 32];
      end
   end

   always_comb begin
      prio_d     = prio_q;
      s1_valid_d = xfer;
      s1_a_d     = s1_a_q;
      s1_tag_d   = s1_tag_q;
      s2_valid_d = s1_valid_q;
      s2_tag_d   = s1_tag_q;
      if (xfer) begin
         prio_d   = (win == PW'(REQUESTERS - 1)) ? '0 : win + PW'(1);
         s1_a_d   = win_a;
         s1_tag_d = win;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_tag_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_tag_q   <= '0;
      end else begin
         prio_q     <= prio_d;
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_tag_q   <= s1_tag_d;
         s2_valid_q <= s2_valid_d;
         s2_tag_q   <= s2_tag_d;
      end
   end

   // The table is unreset, so only s2_valid_q qualifies its output.
   single_exponent_table #(
      .STEPS (STEPS),
      .LIMIT (LIMIT)
   ) u_table (
      .clk       (clk),
      .in_valid  (s1_valid_q),
      .a         (s1_a_q),
      .out_valid (tbl_valid_unused),
      .c         (tbl_c)
   );

   always_comb begin
      resp_valid = '0;
      if (s2_valid_q) resp_valid[s2_tag_q] = 1'b1;
   end

   assign resp_c = s2_valid_q ? tbl_c : 32'h0;
   assign busy   = s1_valid_q | s2_valid_q;

`ifdef SINGLE_EXP_ARB_STATS_EN
   logic [15:0] gcnt_q [REQUESTERS];
   logic [15:0] gcnt_d [REQUESTERS];
   logic [15:0] wait_q [REQUESTERS];
   logic [15:0] wait_d [REQUESTERS];
   logic [15:0] max_wait_q, max_wait_d;

   always_comb begin
      max_wait_d = max_wait_q;
      for (int k = 0; k < REQUESTERS; k++) begin
         gcnt_d[k] = gcnt_q[k];
         wait_d[k] = '0;
         if (grant[k] && gcnt_q[k] != 16'hFFFF) gcnt_d[k] = gcnt_q[k] + 16'd1;
         if (req_valid[k] && !grant[k]) begin
            wait_d[k] = (wait_q[k] == 16'hFFFF) ? wait_q[k] : wait_q[k] + 16'd1;
            if (wait_d[k] > max_wait_d) max_wait_d = wait_d[k];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         max_wait_q <= '0;
         for (int k = 0; k < REQUESTERS; k++) begin
            gcnt_q[k] <= '0;
            wait_q[k] <= '0;
         end
      end else begin
         max_wait_q <= max_wait_d;
         for (int k = 0; k < REQUESTERS; k++) begin
            gcnt_q[k] <= gcnt_d[k];
            wait_q[k] <= wait_d[k];
         end
      end
   end

   for (genvar k = 0; k < REQUESTERS; k++) begin : g_gcnt
      assign grant_count[16*k +: 16] = gcnt_q[k];
   end
   assign max_wait = max_wait_q;
`endif
endmodule

// File: tb/tb_single_exp_table_arbiter.sv
// Randomized self-checking bench for single_exp_table_arbiter against a cycle-level reference model.
// Statistics checks are included when SINGLE_EXP_ARB_STATS_EN is defined.

module tb_single_exp_table_arbiter;
   localparam int  R     = 4;
   localparam int  STEPS = 64;
   localparam real LIMIT = 8.0;

   logic            clk = 1'b0;
   logic            reset;
   logic [R-1:0]    req_valid;
   logic [32*R-1:0] req_a;
   logic [R-1:0]    req_ready;
   logic [R-1:0]    resp_valid;
   logic [31:0]     resp_c;
   logic            busy;
`ifdef SINGLE_EXP_ARB_STATS_EN
   logic [16*R-1:0] grant_count;
   logic [15:0]     max_wait;
`endif

   always #5 clk = ~clk;

   single_exp_table_arbiter #(.REQUESTERS(R), .STEPS(STEPS), .LIMIT(LIMIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_c     (resp_c),
      .busy       (busy)
`ifdef SINGLE_EXP_ARB_STATS_EN
      ,
      .grant_count(grant_count),
      .max_wait   (max_wait)
`endif
   );

   int checks = 0;
   int errors = 0;

   int          m_ptr;
   logic        m_s1_v, m_s2_v;
   int          m_s1_tag, m_s2_tag;
   logic [31:0] m_s1_c, m_s2_c;
   int          m_gcnt [R];
   int          m_wait [R];
   int          m_max;

   logic [R-1:0] pend, stream;
   logic [31:0]  opnd [R];

   logic [R-1:0] obs_rdy, obs_rv;
   logic [31:0]  obs_rc;
   logic         obs_busy;
   logic [15:0]  obs_mw;
   logic [15:0]  obs_gc0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic real bits2real(input logic [31:0] b);
      int  e;
      real r;
      if (b[30:23] == 8'd0) return 0.0;
      e = int'(b[30:23]) - 127;
      r = 1.0 + real'(b[22:0]) / 8388608.0;
      while (e > 0) begin r = r * 2.0; e--; end
      while (e < 0) begin r = r / 2.0; e++; end
      return b[31] ? -r : r;
   endfunction

   function automatic logic [31:0] real2bits(input real v);
      logic s;
      int   e, m;
      real  f;
      if (v == 0.0) return 32'h0;
      s = (v < 0.0);
      f = s ? -v : v;
      e = 0;
      while (f >= 2.0) begin f = f / 2.0; e++; end
      while (f < 1.0)  begin f = f * 2.0; e--; end
      m = $rtoi((f - 1.0) * 8388608.0 + 0.5);
      if (m == 8388608) begin m = 0; e++; end
      return {s, 8'(e + 127), 23'(m)};
   endfunction

   // Clamp to +/-LIMIT, pick the nearest of STEPS evenly spaced points, return exp of it.
   function automatic logic [31:0] exp_model(input logic [31:0] a);
      real x, stp;
      int  idx;
      x = bits2real(a);
      if (x < -LIMIT) x = -LIMIT;
      if (x > LIMIT)  x = LIMIT;
      stp = 2.0 * LIMIT / real'(STEPS - 1);
      idx = $rtoi($floor((x + LIMIT) / stp + 0.5));
      if (idx < 0) idx = 0;
      if (idx > STEPS - 1) idx = STEPS - 1;
      return real2bits($exp(-LIMIT + real'(idx) * stp));
   endfunction

   function automatic logic [31:0] rand_op();
      int n;
      n = int'($urandom_range(0, 40000)) - 20000;
      if (n == 0) n = 1;
      return real2bits(real'(n) / 2000.0);
   endfunction

   function automatic int pick(input logic [R-1:0] p);
      for (int k = 0; k < R; k++) begin
         int i;
         i = (m_ptr + k) % R;
         if (p[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_clear();
      m_ptr = 0; m_s1_v = 0; m_s2_v = 0; m_s1_tag = 0; m_s2_tag = 0;
      m_s1_c = 0; m_s2_c = 0; m_max = 0;
      for (int i = 0; i < R; i++) begin m_gcnt[i] = 0; m_wait[i] = 0; end
   endtask

   task automatic drive();
      req_valid = pend;
      for (int i = 0; i < R; i++) req_a[32*i +: 32] = opnd[i];
   endtask

   task automatic step();
      int w;
      logic [R-1:0] exp_rdy, exp_rv;
      @(negedge clk);
      w = reset ? -1 : pick(pend);
      exp_rdy = (w < 0) ? '0 : (R'(1) << w);
      exp_rv  = m_s2_v ? (R'(1) << m_s2_tag) : '0;
      obs_rdy = req_ready; obs_rv = resp_valid; obs_rc = resp_c; obs_busy = busy;
      check("req_ready", req_ready, exp_rdy);
      check("resp_valid", resp_valid, exp_rv);
      check("resp_c", resp_c, m_s2_v ? m_s2_c : 32'h0);
      check("busy", busy, m_s1_v | m_s2_v);
`ifdef SINGLE_EXP_ARB_STATS_EN
      obs_mw = max_wait; obs_gc0 = grant_count[15:0];
      for (int i = 0; i < R; i++) check("grant_count", grant_count[16*i +: 16], m_gcnt[i]);
      check("max_wait", max_wait, m_max);
`endif
      @(posedge clk); #1;
      if (reset) model_clear();
      else begin
         for (int i = 0; i < R; i++) begin
            if (w == i && m_gcnt[i] < 65535) m_gcnt[i]++;
            if (pend[i] && w != i) begin
               if (m_wait[i] < 65535) m_wait[i]++;
               if (m_wait[i] > m_max) m_max = m_wait[i];
            end else m_wait[i] = 0;
         end
         m_s2_v = m_s1_v; m_s2_tag = m_s1_tag; m_s2_c = m_s1_c;
         m_s1_v = (w >= 0);
         if (w >= 0) begin
            m_s1_tag = w;
            m_s1_c   = exp_model(opnd[w]);
            m_ptr    = (w + 1) % R;
            pend[w]  = stream[w];
            if (stream[w]) opnd[w] = rand_op();
         end
      end
      drive();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      model_clear();
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic drain();
      stream = '0;
      for (int k = 0; k < 20 && pend != '0; k++) step();
      check("drain_done", pend, '0);
      repeat (3) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      logic got3;
      reset = 1'b1;
      pend = '0; stream = '0;
      for (int i = 0; i < R; i++) opnd[i] = rand_op();
      model_clear();
      pend = '1;
      drive();
      repeat (3) step();
      check("rst_ready", obs_rdy, '0);
      check("rst_busy", obs_busy, 1'b0);
      pend = '0;
      drive();
      reset = 1'b0;
      step();

      // single request, exp(8)
      opnd[0] = 32'h41000000; pend[0] = 1'b1; drive();
      step();
      check("single_grant", obs_rdy, 4'b0001);
      step();
      check("single_early", obs_rv, 4'b0000);
      step();
      check("single_rv", obs_rv, 4'b0001);
      check("single_c", obs_rc, 32'h453A4F54);
      drain();

      // clamp low
      opnd[2] = 32'hC1200000; pend[2] = 1'b1; drive();
      repeat (3) step();
      check("clamp_rv", obs_rv, 4'b0100);
      check("clamp_c", obs_rc, real2bits($exp(-8.0)));
      drain();

      // all four streaming from reset
      pend = '1; stream = '1; drive();
      do_reset(2);
      for (int k = 0; k < 8; k++) begin
         step();
         check("rr_order", obs_rdy, R'(1) << (k % R));
      end
      drain();

      // fairness: client 1 streams, client 3 asserts once
      stream[1] = 1'b1; pend[1] = 1'b1; drive();
      step(); step();
      pend[3] = 1'b1; drive();
      waited = 0; got3 = 1'b0;
      for (int k = 0; k < 6 && !got3; k++) begin
         step();
         if (obs_rdy[3]) got3 = 1'b1; else waited++;
      end
      check("fair_granted", got3, 1'b1);
      check("fair_wait", waited <= 1, 1'b1);
      drain();

      // reset mid-flight
      pend = 4'b0011; drive();
      step(); step(); step();
      reset = 1'b1; model_clear();
      pend = 4'b1010; drive();
      step(); step();
      reset = 1'b0;
      step();
      check("post_rst_grant", obs_rdy, 4'b0010);
      check("post_rst_busy", obs_busy, 1'b0);
      check("post_rst_rv", obs_rv, 4'b0000);
      drain();

`ifdef SINGLE_EXP_ARB_STATS_EN
      do_reset(1);
      pend = 4'b0001; drive();
      step();
      pend = 4'b1111; drive();
      repeat (5) step();
      check("stats_max_wait", obs_mw, 16'd3);
      check("stats_gcnt0", obs_gc0, 16'd2);
      drain();
`endif

      // random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < R; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               opnd[i] = rand_op();
            end
            stream[i] = ($urandom_range(0, 7) == 0);
         end
         drive();
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1; model_clear();
            step();
            reset = 1'b0;
         end else step();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/single_exp_table_arbiter.md
Name: single_exp_table_arbiter

Overview:
- Shares one single_exponent_table instance among REQUESTERS independent clients using round-robin arbitration.
- Each client presents a 32-bit single-precision operand with a valid/ready handshake.
- The arbiter registers the winning operand, feeds the table, and returns the result to the originating client with a one-hot response strobe.
- Sits between activation/softmax pipelines and the shared exponent lookup.

Parameters:
REQUESTERS, 4, number of clients (2..16)
STEPS, 64, passed to the table: number of table entries
LIMIT, 8.0, passed to the table: input clamp magnitude

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  REQUESTERS  per-client request valid
req_a  input  32*REQUESTERS  per-client operand; client i uses bits [32*i+31:32*i]
req_ready  output  REQUESTERS  per-client accept strobe
resp_valid  output  REQUESTERS  one-hot result strobe
resp_c  output  32  result value, shared by all clients
busy  output  1  at least one accepted request is in flight

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high. While reset=1:
  - prio_ptr=0; stage-1 and stage-2 valid/tag registers cleared.
  - resp_valid=0, resp_c=0, busy=0, req_ready=0.
  - Requests arriving during reset are ignored.
- Arbitration (combinational, every cycle, reset=0):
  - Search req_valid starting at index prio_ptr, wrapping modulo REQUESTERS.
  - The first set bit wins; req_ready = one-hot of the winner; all zeros if no req_valid.
  - A transfer occurs when req_valid[i] & req_ready[i].
  - At most one transfer per cycle. No backpressure exists, so a grant is issued every cycle a request is pending.
- prio_ptr update:
  - On a transfer to client i, prio_ptr <= (i+1) mod REQUESTERS.
  - Otherwise prio_ptr holds.
- Client rules:
  - A client holds req_valid and req_a stable until it sees req_ready.
  - A client may keep req_valid high to issue back-to-back requests; it is then re-granted only after every other waiting client has been served.
- Pipeline:
  - Stage 1 (edge after transfer): s1_valid<=1, s1_a<=operand, s1_tag<=i.
  - s1_valid and s1_a drive the table's in_valid and a.
  - Stage 2 (table register, next edge): s2_valid<=s1_valid, s2_tag<=s1_tag.
  - Response outputs are driven combinationally from stage 2: resp_valid = s2_valid ? onehot(s2_tag) : 0, and resp_c = table c when s2_valid, else 0.
  - Latency: transfer in cycle t produces resp_valid in cycle t+2. Throughput is one result per cycle.
- Table out_valid: the table has no reset, so its out_valid is ignored. Only the arbiter's reset-cleared s2_valid qualifies responses.
- busy = s1_valid | s2_valid.
- Reset mid-operation: in-flight operations are discarded and no resp_valid is produced for them after reset deasserts. The first post-reset grant goes to the lowest-indexed requesting client.
- Simultaneous events: a new transfer in the same cycle a response is emitted is legal. Response and request paths are independent.

Optional Feature:
Macro SINGLE_EXP_ARB_STATS_EN.
- Defined:
  - Adds output grant_count, width 16*REQUESTERS. Field i is a saturating count of transfers to client i (holds at 16'hFFFF).
  - Adds output max_wait, width 16: the largest number of consecutive cycles any client held req_valid without req_ready, saturating.
  - All counters clear on reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single request: client 0 sends 0x41000000 (8.0) -> resp_valid=4'b0001 exactly 2 cycles after the transfer, resp_c=0x453A4F54 (exp(8)).
- Clamp low: client 2 sends 0xC1200000 (-10.0) -> resp_valid=4'b0100, resp_c = table entry 0 (exp(-8) ≈ 3.3546e-4).
- All four clients hold req_valid for 8 cycles from reset -> grants in order 0,1,2,3,0,1,2,3; one response per cycle; each resp_c matches that client's operand.
- Fairness: client 1 streams continuously, client 3 asserts once -> client 3 is granted within 1 cycle after client 1's next grant, and is never starved.
- Reset mid-flight: assert reset 1 cycle after two transfers -> no resp_valid after release; busy=0; the next grant goes to the lowest requester.
- STATS_EN: client 0 waits 3 cycles behind 1, 2, 3 -> max_wait=3; grant_count[0] increments once per transfer.
